// File: rtl/snap_ctrl_pkg.sv
// Shared types and constants for the snapshot capture controller.
package snap_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;
    localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/snap_edge_det.sv
// Registered rising-edge detector: one-cycle pulse in the cycle after the level rises.
module snap_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // History register plus registered pulse; both clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: arm, trigger, skip offset, fill BRAM, report done.
//
// state   | meaning
// IDLE    | out of reset, waiting for the first arm
// ARMED   | waiting for an enabled trigger
// DELAY   | skipping 'offset' valid samples after the trigger
// CAPTURE | writing one BRAM word per valid sample
// DONE    | capture finished or stopped; holds until the next arm
module snap_capture_ctrl
    import snap_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int OFFSET_W = 32
) (
    input  logic                OPB_Clk,
    input  logic                OPB_Rst,
    input  logic                ctrl_arm,
    input  logic                ctrl_stop,
    input  logic                trig_en,
    input  logic                trig_ext,
    input  logic                trig_sw,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                data_valid,
    output logic                bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic                status_busy,
    output logic                status_done,
    output logic [ADDR_W:0]     status_count,
    output logic [31:0]         tr_en_cnt
);

    localparam logic [ADDR_W-1:0]   LAST_ADDR = '1;
    localparam logic [ADDR_W:0]     COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [OFFSET_W-1:0] DELAY_ONE = OFFSET_W'(1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   wr_addr;
    logic [OFFSET_W-1:0] delay_cnt;

    logic arm_pulse;
    logic stop_pulse;
    logic trig_edge;
    logic trig;
    logic busy_state;
    logic stop_hit;
    logic cap_write;

    snap_edge_det u_arm_edge (
        .clk   (OPB_Clk),
        .rst   (OPB_Rst),
        .level (ctrl_arm),
        .pulse (arm_pulse)
    );

    snap_edge_det u_stop_edge (
        .clk   (OPB_Clk),
        .rst   (OPB_Rst),
        .level (ctrl_stop),
        .pulse (stop_pulse)
    );

    // Either trigger source rising counts as one trigger event.
    snap_edge_det u_trig_edge (
        .clk   (OPB_Clk),
        .rst   (OPB_Rst),
        .level (trig_ext | trig_sw),
        .pulse (trig_edge)
    );

    assign trig       = trig_edge & trig_en;
    assign busy_state = (state == ST_ARMED) || (state == ST_DELAY) || (state == ST_CAPTURE);
    assign stop_hit   = stop_pulse && busy_state;
    // Arm and stop both pre-empt a sample landing in the same cycle.
    assign cap_write  = (state == ST_CAPTURE) && data_valid && !arm_pulse && !stop_hit;

    // State register.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; arm beats stop beats everything else.
    always_comb begin
        state_nxt = state;
        if (arm_pulse) begin
            state_nxt = ST_ARMED;
        end else if (stop_hit) begin
            state_nxt = ST_DONE;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (trig) begin
                        state_nxt = (offset == '0) ? ST_CAPTURE : ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (data_valid && (delay_cnt == DELAY_ONE)) begin
                        state_nxt = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (cap_write && (wr_addr == LAST_ADDR)) begin
                        state_nxt = ST_DONE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Status flags decode straight from the state so async reset clears them at once.
    always_comb begin
        status_busy = busy_state;
        status_done = (state == ST_DONE);
    end

    // Write strobe, addressing, delay counter and trigger-enable counter.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            wr_addr      <= '0;
            status_count <= '0;
            delay_cnt    <= '0;
            tr_en_cnt    <= '0;
        end else begin
            bram_we <= cap_write;
            if (arm_pulse) begin
                wr_addr      <= '0;
                status_count <= '0;
                delay_cnt    <= '0;
                tr_en_cnt    <= '0;
            end else begin
                if (trig && (state != ST_IDLE)) begin
                    tr_en_cnt <= sat_inc(tr_en_cnt);
                end
                if (cap_write) begin
                    bram_addr    <= wr_addr;
                    status_count <= status_count + COUNT_ONE;
                    // Last address ends the capture, so the pointer never wraps.
                    if (wr_addr != LAST_ADDR) begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
                if ((state == ST_ARMED) && trig && !stop_hit) begin
                    delay_cnt <= offset;
                end else if ((state == ST_DELAY) && data_valid && !stop_hit && (delay_cnt != '0)) begin
                    delay_cnt <= delay_cnt - DELAY_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Self-checking bench for snap_capture_ctrl against a sample-counting reference model.
module tb_snap_capture_ctrl;

    localparam int AW       = 11;
    localparam int DEPTH_TB = 1 << AW;

    logic        OPB_Clk;
    logic        OPB_Rst;
    logic        ctrl_arm;
    logic        ctrl_stop;
    logic        trig_en;
    logic        trig_ext;
    logic        trig_sw;
    logic [31:0] offset;
    logic        data_valid;
    logic        bram_we;
    logic [AW-1:0] bram_addr;
    logic        status_busy;
    logic        status_done;
    logic [AW:0] status_count;
    logic [31:0] tr_en_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int seen_writes = 0;

    // Reference model: what the capture has done so far, in sample terms.
    localparam int P_OFF  = 0;  // never armed since reset
    localparam int P_WAIT = 1;  // armed, waiting for an enabled trigger
    localparam int P_SKIP = 2;  // discarding post-trigger samples
    localparam int P_FILL = 3;  // storing samples
    localparam int P_END  = 4;  // finished or stopped

    int          m_phase;
    longint      m_skip;
    int          m_written;
    logic [31:0] m_trigs;
    logic        m_we;
    int          m_addr;
    logic        arm_h1, arm_h2, stop_h1, stop_h2, trg_h1, trg_h2;

    snap_capture_ctrl #(.ADDR_W(AW), .OFFSET_W(32)) dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst      (OPB_Rst),
        .ctrl_arm     (ctrl_arm),
        .ctrl_stop    (ctrl_stop),
        .trig_en      (trig_en),
        .trig_ext     (trig_ext),
        .trig_sw      (trig_sw),
        .offset       (offset),
        .data_valid   (data_valid),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .status_busy  (status_busy),
        .status_done  (status_done),
        .status_count (status_count),
        .tr_en_cnt    (tr_en_cnt)
    );

    initial OPB_Clk = 1'b0;
    always #5 OPB_Clk = ~OPB_Clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_phase = P_OFF; m_skip = 0; m_written = 0; m_trigs = 32'd0;
        m_we = 1'b0; m_addr = 0;
        arm_h1 = 0; arm_h2 = 0; stop_h1 = 0; stop_h2 = 0; trg_h1 = 0; trg_h2 = 0;
    endtask

    // One clock edge of the model; an event is seen one cycle after its level rose.
    task automatic model_step();
        logic arm_ev, stop_ev, trg_ev, busy;
        arm_ev  = arm_h1 && !arm_h2;
        stop_ev = stop_h1 && !stop_h2;
        trg_ev  = trg_h1 && !trg_h2 && trig_en;
        arm_h2 = arm_h1;  arm_h1 = ctrl_arm;
        stop_h2 = stop_h1; stop_h1 = ctrl_stop;
        trg_h2 = trg_h1;  trg_h1 = trig_ext | trig_sw;
        m_we = 1'b0;
        if (arm_ev) begin
            m_phase = P_WAIT; m_written = 0; m_trigs = 32'd0;
        end else begin
            if (trg_ev && m_phase != P_OFF && m_trigs != 32'hFFFF_FFFF) m_trigs = m_trigs + 32'd1;
            busy = (m_phase == P_WAIT) || (m_phase == P_SKIP) || (m_phase == P_FILL);
            if (stop_ev && busy) begin
                m_phase = P_END;
            end else if (m_phase == P_WAIT) begin
                if (trg_ev) begin
                    m_skip  = longint'(offset);
                    m_phase = (m_skip == 0) ? P_FILL : P_SKIP;
                end
            end else if (m_phase == P_SKIP) begin
                if (data_valid) begin
                    m_skip = m_skip - 1;
                    if (m_skip == 0) m_phase = P_FILL;
                end
            end else if (m_phase == P_FILL) begin
                if (data_valid) begin
                    m_we = 1'b1; m_addr = m_written; m_written = m_written + 1;
                    if (m_written == DEPTH_TB) m_phase = P_END;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic exp_busy;
        exp_busy = (m_phase == P_WAIT) || (m_phase == P_SKIP) || (m_phase == P_FILL);
        check("bram_we", 64'(bram_we), 64'(m_we));
        if (m_we) check("bram_addr", 64'(bram_addr), 64'(m_addr));
        check("status_busy", 64'(status_busy), 64'(exp_busy));
        check("status_done", 64'(status_done), 64'(m_phase == P_END));
        check("status_count", 64'(status_count), 64'(m_written));
        check("tr_en_cnt", 64'(tr_en_cnt), 64'(m_trigs));
        if (bram_we === 1'b1) seen_writes++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge OPB_Clk);
            model_step();
            @(negedge OPB_Clk);
            check_all();
        end
    endtask

    task automatic do_arm();
        ctrl_arm = 1'b1; tick(2); ctrl_arm = 1'b0; tick(2);
    endtask

    task automatic do_stop();
        ctrl_stop = 1'b1; tick(2); ctrl_stop = 1'b0; tick(1);
    endtask

    task automatic ext_trig();
        trig_ext = 1'b1; tick(2); trig_ext = 1'b0; tick(2);
    endtask

    task automatic sw_trig();
        trig_sw = 1'b1; tick(2); trig_sw = 1'b0; tick(2);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (status_done !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        check(tag, 64'(status_done), 64'd1);
    endtask

    initial begin
        OPB_Rst = 1'b1; ctrl_arm = 0; ctrl_stop = 0; trig_en = 1; trig_ext = 0; trig_sw = 0;
        offset = 32'd0; data_valid = 0;
        model_reset();
        repeat (2) @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
        check("rst_we", 64'(bram_we), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_busy", 64'(status_busy), 64'd0);
        check("rst_done", 64'(status_done), 64'd0);
        check("rst_count", 64'(status_count), 64'd0);
        check("rst_tr", 64'(tr_en_cnt), 64'd0);
        tick(3);

        // Full-depth capture, offset 0, continuous valid.
        do_arm();
        data_valid = 1'b1;
        seen_writes = 0;
        ext_trig();
        wait_done("full_done", 2200);
        check("full_writes", 64'(seen_writes), 64'd2048);
        check("full_count", 64'(status_count), 64'd2048);
        check("full_tr", 64'(tr_en_cnt), 64'd1);
        data_valid = 1'b0;
        tick(3);

        // Offset 5 with valid on alternate cycles: 20 valid samples, 5 skipped.
        offset = 32'd5;
        do_arm();
        ext_trig();
        seen_writes = 0;
        for (int i = 0; i < 40; i++) begin
            data_valid = (i % 2) == 1;
            tick(1);
        end
        data_valid = 1'b0;
        check("ofs_writes", 64'(seen_writes), 64'd15);
        check("ofs_count", 64'(status_count), 64'd15);
        do_stop();
        check("ofs_stop_done", 64'(status_done), 64'd1);

        // Stop after exactly 100 writes; nothing written afterwards.
        offset = 32'd0;
        do_arm();
        ext_trig();
        data_valid = 1'b1;
        tick(100);
        data_valid = 1'b0;
        check("stop_count_pre", 64'(status_count), 64'd100);
        do_stop();
        seen_writes = 0;
        data_valid = 1'b1;
        tick(10);
        data_valid = 1'b0;
        check("stop_no_we", 64'(seen_writes), 64'd0);
        check("stop_done", 64'(status_done), 64'd1);
        check("stop_count", 64'(status_count), 64'd100);

        // Disabled triggers are ignored; a capture-time trigger counts but does not restart.
        do_arm();
        trig_en = 1'b0;
        repeat (3) ext_trig();
        check("dis_tr", 64'(tr_en_cnt), 64'd0);
        check("dis_count", 64'(status_count), 64'd0);
        trig_en = 1'b1;
        data_valid = 1'b1;
        sw_trig();
        tick(10);
        sw_trig();
        tick(10);
        check("en_tr", 64'(tr_en_cnt), 64'd2);
        check("en_busy", 64'(status_busy), 64'd1);
        data_valid = 1'b0;
        do_stop();

        // Arm and trigger rising together: trigger is dropped.
        ctrl_arm = 1'b1; trig_ext = 1'b1;
        tick(2);
        ctrl_arm = 1'b0; trig_ext = 1'b0;
        tick(2);
        data_valid = 1'b1;
        tick(5);
        check("same_busy", 64'(status_busy), 64'd1);
        check("same_tr", 64'(tr_en_cnt), 64'd0);
        check("same_count", 64'(status_count), 64'd0);
        ext_trig();
        tick(3);
        check("same_later_tr", 64'(tr_en_cnt), 64'd1);
        data_valid = 1'b0;
        do_stop();

        // Asynchronous reset in the cycle address 37 is being written.
        do_arm();
        data_valid = 1'b1;
        ext_trig();
        begin
            int n;
            n = 0;
            while (!(bram_we === 1'b1 && bram_addr == 11'd37) && n < 200) begin
                tick(1);
                n++;
            end
            check("rst37_reached", 64'(bram_addr), 64'd37);
        end
        #2 OPB_Rst = 1'b1;
        model_reset();
        #1;
        check("arst_we", 64'(bram_we), 64'd0);
        check("arst_busy", 64'(status_busy), 64'd0);
        check("arst_count", 64'(status_count), 64'd0);
        check("arst_tr", 64'(tr_en_cnt), 64'd0);
        check("arst_addr", 64'(bram_addr), 64'd0);
        data_valid = 1'b0;
        @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
        tick(2);
        do_arm();
        data_valid = 1'b1;
        ext_trig();
        check("rearm_count", 64'(status_count), 64'd2);
        data_valid = 1'b0;
        do_stop();

        // Randomized traffic: valid, enable, software trigger, stop and arm all random.
        for (int r = 0; r < 6; r++) begin
            offset = $urandom_range(0, 12);
            do_arm();
            for (int c = 0; c < 150; c++) begin
                data_valid = $urandom_range(0, 3) != 0;
                trig_en    = $urandom_range(0, 3) != 0;
                trig_sw    = $urandom_range(0, 5) == 0;
                ctrl_stop  = (c > 100) && ($urandom_range(0, 15) == 0);
                ctrl_arm   = $urandom_range(0, 60) == 0;
                tick(1);
            end
            data_valid = 0; trig_sw = 0; ctrl_stop = 0; ctrl_arm = 0; trig_en = 1;
            tick(3);
        end

        // Randomized full-depth run with sparse valid and random offset.
        offset = $urandom_range(0, 30);
        do_arm();
        ext_trig();
        begin
            int n;
            n = 0;
            while (status_done !== 1'b1 && n < 4000) begin
                data_valid = $urandom_range(0, 3) != 0;
                tick(1);
                n++;
            end
        end
        check("rnd_full_done", 64'(status_done), 64'd1);
        check("rnd_full_count", 64'(status_count), 64'd2048);
        data_valid = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
